ibex_irq_ctrl: RTL and testbench

//  Parametrised interrupt front-end for the next-generation core controller.

---
 rtl/ibex_irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_ibex_irq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_irq_ctrl.sv
// Interrupt front-end: registers, masks and arbitrates irqs and NMI for the core controller.
// Define IBEX_IRQ_VECTORED_EN to add vec_mode_i / irq_vec_o (vectored handler offset).
module ibex_irq_ctrl #(
  parameter int unsigned NUM_FAST = 15,
  parameter logic [4:0]  NMI_CODE = 5'd31
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                irq_software_i,
  input  logic                irq_timer_i,
  input  logic                irq_external_i,
  input  logic [NUM_FAST-1:0] irq_fast_i,
  input  logic                irq_nm_i,
  input  logic [NUM_FAST+2:0] mie_i,
  input  logic                mstatus_mie_i,
  input  logic                debug_mode_i,
  input  logic                ctrl_ready_i,
  input  logic                irq_ack_i,
  input  logic                nmi_done_i,
`ifdef IBEX_IRQ_VECTORED_EN
  input  logic                vec_mode_i,
  output logic [7:0]          irq_vec_o,
`endif
  output logic                irq_req_o,
  output logic [5:0]          irq_cause_o,
  output logic                irq_nmi_o,
  output logic [NUM_FAST+2:0] mip_o,
  output logic                wake_o
);

  typedef enum logic {
    IDLE,
    REQ
  } state_e;

  state_e state_q, state_d;

  logic [NUM_FAST+2:0] mip_q, mip_d;
  logic                prev_nm_q;
  logic                nmi_pend_q, nmi_pend_d;
  logic                nmi_act_q, nmi_act_d;
  logic [5:0]          cause_q, cause_d;
  logic                nmi_q, nmi_d;

  logic [NUM_FAST+2:0] en_irqs;
  logic                nm_edge;
  logic                sel_valid;
  logic [4:0]          sel_code;
  logic                cand;
  logic [4:0]          cand_code;
  logic                take;
  logic                nmi_ack;

  assign mip_d   = {irq_fast_i, irq_external_i,
                    irq_timer_i, irq_software_i};
  assign en_irqs = mip_q & mie_i;
  assign nm_edge = irq_nm_i & ~prev_nm_q;

  // Lowest priority first; later hits overwrite earlier ones.
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = 5'd0;
    if (en_irqs[1]) begin
      sel_valid = 1'b1;
      sel_code  = 5'd7;
    end
    if (en_irqs[0]) begin
      sel_valid = 1'b1;
      sel_code  = 5'd3;
    end
    if (en_irqs[2]) begin
      sel_valid = 1'b1;
      sel_code  = 5'd11;
    end
    for (int k = int'(NUM_FAST) - 1; k >= 0; k--) begin
      if (en_irqs[3+k]) begin
        sel_valid = 1'b1;
        sel_code  = 5'(16 + k);
      end
    end
  end

  assign cand      = ~nmi_act_q &
                     (nmi_pend_q | (mstatus_mie_i & sel_valid));
  assign cand_code = nmi_pend_q ? NMI_CODE : sel_code;
  assign take      = (state_q == IDLE) & cand &
                     ctrl_ready_i & ~debug_mode_i;
  assign nmi_ack   = (state_q == REQ) & irq_ack_i & nmi_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take) state_d = REQ;
      REQ:  if (irq_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge in the ack cycle keeps the NMI pending.
  assign nmi_pend_d = nm_edge | (nmi_pend_q & ~nmi_ack);
  assign nmi_act_d  = nmi_ack | (nmi_act_q & ~nmi_done_i);
  assign cause_d    = take ? {1'b1, cand_code} : cause_q;
  assign nmi_d      = take ? nmi_pend_q : nmi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mip_q      <= '0;
      prev_nm_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_act_q  <= 1'b0;
      cause_q    <= 6'd0;
      nmi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mip_q      <= mip_d;
      prev_nm_q  <= irq_nm_i;
      nmi_pend_q <= nmi_pend_d;
      nmi_act_q  <= nmi_act_d;
      cause_q    <= cause_d;
      nmi_q      <= nmi_d;
    end
  end

`ifdef IBEX_IRQ_VECTORED_EN
  logic [7:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (take) begin
      if (nmi_pend_q)      vec_d = 8'h7C;
      else if (vec_mode_i) vec_d = {1'b0, cand_code, 2'b00};
      else                 vec_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vec_q <= 8'h00;
    else         vec_q <= vec_d;
  end

  assign irq_vec_o = vec_q;
`endif

  assign irq_req_o   = (state_q == REQ);
  assign irq_cause_o = cause_q;
  assign irq_nmi_o   = nmi_q & (state_q == REQ);
  assign mip_o       = mip_q;
  assign wake_o      = (|en_irqs) | nmi_pend_q;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Bench for ibex_irq_ctrl: vector table, corner sequences, random vs reference model.
// Define IBEX_IRQ_VECTORED_EN to also exercise irq_vec_o.
module tb_ibex_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw, tmr, ext, nm;
  logic [14:0] fast;
  logic [17:0] mie;
  logic        mst, dbg, rdy, ack, done;
  logic        req, nmi_o, wake;
  logic [5:0]  cause;
  logic [17:0] mip;
`ifdef IBEX_IRQ_VECTORED_EN
  logic        vmode;
  logic [7:0]  vec;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ibex_irq_ctrl #(.NUM_FAST(15), .NMI_CODE(5'd31)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .irq_software_i(sw), .irq_timer_i(tmr),
    .irq_external_i(ext), .irq_fast_i(fast),
    .irq_nm_i(nm), .mie_i(mie),
    .mstatus_mie_i(mst), .debug_mode_i(dbg),
    .ctrl_ready_i(rdy), .irq_ack_i(ack),
    .nmi_done_i(done),
`ifdef IBEX_IRQ_VECTORED_EN
    .vec_mode_i(vmode), .irq_vec_o(vec),
`endif
    .irq_req_o(req), .irq_cause_o(cause),
    .irq_nmi_o(nmi_o), .mip_o(mip), .wake_o(wake)
  );

  task automatic chk(string nm_s, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm_s, act, exp);
    end
  endtask

  task automatic clr_in();
    sw = 0; tmr = 0; ext = 0; nm = 0; fast = '0;
    mie = '0; mst = 0; dbg = 0; rdy = 0; ack = 0; done = 0;
`ifdef IBEX_IRQ_VECTORED_EN
    vmode = 0;
`endif
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Reference model: priority list walked in order
  int m_mip, m_prev, m_pend, m_act, m_req, m_nmi;
  logic [5:0] m_cause;

  function automatic int code_of(int idx);
    if (idx == 0) return 3;
    if (idx == 1) return 7;
    if (idx == 2) return 11;
    return 16 + (idx - 3);
  endfunction

  function automatic int best(logic [17:0] en);
    int order[18];
    for (int k = 0; k < 15; k++) order[k] = 3 + k;
    order[15] = 2;
    order[16] = 0;
    order[17] = 1;
    for (int i = 0; i < 18; i++)
      if (en[order[i]]) return code_of(order[i]);
    return -1;
  endfunction

  task automatic model_reset();
    m_mip = 0; m_prev = 0; m_pend = 0; m_act = 0;
    m_req = 0; m_nmi = 0; m_cause = '0;
  endtask

  task automatic model_step();
    int c, old_req, old_nmi, nack;
    logic [17:0] cur;
    cur = 18'(m_mip);
    c = best(cur & mie);
    old_req = m_req;
    old_nmi = m_nmi;
    if (m_req != 0) begin
      if (ack) m_req = 0;
    end else if (m_act == 0 && rdy && !dbg &&
                 (m_pend != 0 || (mst && c >= 0))) begin
      m_req = 1;
      m_nmi = m_pend;
      m_cause = (m_pend != 0) ? 6'h3F : 6'(32 + c);
    end
    nack = (old_req != 0 && ack && old_nmi != 0) ? 1 : 0;
    m_pend = ((m_pend != 0 && nack == 0) ||
              (nm && m_prev == 0)) ? 1 : 0;
    m_act = (nack != 0 || (m_act != 0 && !done)) ? 1 : 0;
    m_mip = int'({fast, ext, tmr, sw});
    m_prev = nm ? 1 : 0;
  endtask

  typedef struct {
    logic        sw, tmr, ext;
    logic [14:0] fast;
    logic [17:0] mie;
    logic        mst;
    logic        req;
    logic [5:0]  cause;
    logic        wake;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{0, 1, 0, 15'h0000, 18'h00002, 1, 1, 6'h27, 1};
    tv[1] = '{1, 1, 0, 15'h0004, 18'h3FFFF, 1, 1, 6'h32, 1};
    tv[2] = '{1, 1, 0, 15'h0000, 18'h3FFFF, 1, 1, 6'h23, 1};
    tv[3] = '{1, 0, 1, 15'h0000, 18'h3FFFF, 1, 1, 6'h2B, 1};
    tv[4] = '{0, 0, 0, 15'h4001, 18'h3FFFF, 1, 1, 6'h30, 1};
    tv[5] = '{0, 0, 0, 15'h4000, 18'h3FFFF, 1, 1, 6'h3E, 1};
    tv[6] = '{0, 1, 0, 15'h0000, 18'h00002, 0, 0, 6'h00, 1};
    tv[7] = '{0, 1, 0, 15'h0000, 18'h3FFFD, 1, 0, 6'h00, 0};
    tv[8] = '{1, 1, 1, 15'h7FFF, 18'h00007, 1, 1, 6'h2B, 1};
    tv[9] = '{0, 0, 0, 15'h0088, 18'h3FFFF, 1, 1, 6'h33, 1};

    do_reset();
    @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_nmi", 32'(nmi_o), 0);
    chk("rst_mip", 32'(mip), 0);
    chk("rst_wake", 32'(wake), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      sw = tv[i].sw; tmr = tv[i].tmr; ext = tv[i].ext;
      fast = tv[i].fast; mie = tv[i].mie;
      mst = tv[i].mst; rdy = 1;
      @(negedge clk);
      chk($sformatf("tv%0d_lat", i), 32'(req), 0);
      @(negedge clk);
      chk($sformatf("tv%0d_req", i), 32'(req), 32'(tv[i].req));
      chk($sformatf("tv%0d_wake", i), 32'(wake), 32'(tv[i].wake));
      if (tv[i].req)
        chk($sformatf("tv%0d_cause", i), 32'(cause), 32'(tv[i].cause));
    end

    // Cause held while sources change, re-request gap after ack
    do_reset();
    sw = 1; tmr = 1; fast = 15'h0004; mie = '1; mst = 1; rdy = 1;
    repeat (2) @(negedge clk);
    chk("hold_req0", 32'(cause), 32'h32);
    fast = 15'h0001;
    repeat (3) @(negedge clk);
    chk("hold_req", 32'(req), 1);
    chk("hold_cause", 32'(cause), 32'h32);
    rdy = 0;
    @(negedge clk);
    chk("hold_rdy", 32'(req), 1);
    rdy = 1; ack = 1;
    @(negedge clk);
    chk("ack_drop", 32'(req), 0);
    ack = 0;
    @(negedge clk);
    chk("rereq", 32'(req), 1);
    chk("rereq_cause", 32'(cause), 32'h30);

    // NMI: single request per edge, blocked until nmi_done
    do_reset();
    mst = 0; rdy = 1; nm = 1;
    @(negedge clk);
    chk("nmi_lat", 32'(req), 0);
    @(negedge clk);
    chk("nmi_req", 32'(req), 1);
    chk("nmi_cause", 32'(cause), 32'h3F);
    chk("nmi_flag", 32'(nmi_o), 1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    begin
      int cnt = 0;
      repeat (8) begin
        @(negedge clk);
        if (req) cnt++;
      end
      chk("nmi_noreq", 32'(cnt), 0);
    end
    done = 1;
    @(negedge clk);
    done = 0;
    repeat (3) @(negedge clk);
    chk("nmi_noedge", 32'(req), 0);
    nm = 0;
    @(negedge clk);
    nm = 1;
    repeat (2) @(negedge clk);
    chk("nmi_req2", 32'(req), 1);
    chk("nmi_flag2", 32'(nmi_o), 1);

    // Debug mode holds off the request but not wake
    do_reset();
    ext = 1; mie = 18'h4; mst = 1; rdy = 1; dbg = 1;
    repeat (4) @(negedge clk);
    chk("dbg_req", 32'(req), 0);
    chk("dbg_wake", 32'(wake), 1);
    dbg = 0;
    @(negedge clk);
    chk("dbg_rel_req", 32'(req), 1);
    chk("dbg_rel_cause", 32'(cause), 32'h2B);

    // Async reset in the middle of a request
    do_reset();
    tmr = 1; mie = 18'h2; mst = 1; rdy = 1;
    repeat (2) @(negedge clk);
    chk("arst_pre", 32'(req), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_req", 32'(req), 0);
    chk("arst_mip", 32'(mip), 0);
    chk("arst_cause", 32'(cause), 0);
    clr_in();
    @(negedge clk);
    rst_n = 1;

`ifdef IBEX_IRQ_VECTORED_EN
    do_reset();
    vmode = 1; sw = 1; mie = 18'h1; mst = 1; rdy = 1;
    repeat (2) @(negedge clk);
    chk("vec_sw", 32'(vec), 32'h0C);
    vmode = 0; ack = 1;
    @(negedge clk);
    ack = 0;
    @(negedge clk);
    chk("vec_off", 32'(vec), 32'h00);
    sw = 0; ack = 1;
    @(negedge clk);
    ack = 0; nm = 1; vmode = 1;
    repeat (2) @(negedge clk);
    chk("vec_nmi", 32'(vec), 32'h7C);
`endif

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sw   = ($urandom % 8) == 0;
      tmr  = ($urandom % 8) == 0;
      ext  = ($urandom % 8) == 0;
      fast = 15'($urandom & $urandom & $urandom);
      if (cyc % 50 == 0) mie = 18'($urandom);
      if (cyc % 20 == 0) dbg = ($urandom % 10) == 0;
      mst  = ($urandom % 100) < 85;
      rdy  = ($urandom % 100) < 70;
      ack  = ($urandom % 100) < 30;
      done = ($urandom % 100) < 5;
      if (($urandom % 10) == 0) nm = ~nm;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_req", 32'(req), 32'(m_req));
      chk("rnd_nmi", 32'(nmi_o), 32'((m_req != 0) && (m_nmi != 0)));
      if (m_req != 0) chk("rnd_cause", 32'(cause), 32'(m_cause));
      chk("rnd_mip", 32'(mip), 32'(m_mip));
      chk("rnd_wake", 32'(wake),
          32'(((18'(m_mip) & mie) != 0) || (m_pend != 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
